// File: rtl/hamming_serial_rx.sv
// Serial receiver for Hamming(12,8) codewords.
// Collects one codeword bit per accepted beat, computes the syndrome,
// corrects single-bit errors and offers the data byte plus error status
// on a valid/ready output port.
// Define HAMMING_SECDED_EN to receive 13-bit frames. In that build the extra
// bit H[12] is overall even parity, and double errors are flagged instead of
// being miscorrected.
module hamming_serial_rx #(
   parameter int LSB_FIRST = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   input  logic       s_bit,
   input  logic       s_sof,
   output logic       s_ready,
   output logic       m_valid,
   input  logic       m_ready,
   output logic [7:0] m_data,
   output logic       m_corrected,
   output logic [3:0] m_err_pos,
   output logic       m_uncorr
);

`ifdef HAMMING_SECDED_EN
   localparam int FRAME_BITS = 13;
`else
   localparam int FRAME_BITS = 12;
`endif

   localparam logic [1:0] ST_SHIFT  = 2'd0;
   localparam logic [1:0] ST_DECODE = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   logic [1:0]            state;
   logic [3:0]            bit_count;
   logic [FRAME_BITS-1:0] frame;
   logic [FRAME_BITS-1:0] frame_shifted;
   logic                  accept;
   logic                  take_bit;
   logic                  out_free;
   logic                  load_out;

   logic [11:0] code;
   logic [11:0] flip_mask;
   logic [11:0] fixed;
   logic [3:0]  syndrome;
   logic        flip_en;
   logic        corr;
   logic        uncorr;
   logic [7:0]  data;

   assign s_ready  = (state == ST_SHIFT);
   assign accept   = s_valid && s_ready;
   // A bit belongs to a frame only once a start-of-frame has been seen.
   assign take_bit = accept && (s_sof || (bit_count != 4'd0));
   assign out_free = !m_valid || m_ready;
   assign load_out = ((state == ST_DECODE) || (state == ST_HOLD)) && out_free;

   // After FRAME_BITS shifts the first received bit sits at the end that
   // matches its codeword index, so frame[i] == H[i] in either bit order.
   generate
      if (LSB_FIRST != 0) begin : g_lsb
         assign frame_shifted = {s_bit, frame[FRAME_BITS-1:1]};
      end else begin : g_msb
         assign frame_shifted = {frame[FRAME_BITS-2:0], s_bit};
      end
   endgenerate

   // Shift register holding the codeword being received.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame <= '0;
      end else if (take_bit) begin
         frame <= frame_shifted;
      end
   end

   // Bit counter and frame/decode/hold sequencing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_SHIFT;
         bit_count <= 4'd0;
      end else begin
         case (state)
            ST_SHIFT: begin
               if (accept) begin
                  if (s_sof) begin
                     bit_count <= 4'd1;
                  end else if (bit_count == 4'(FRAME_BITS - 1)) begin
                     bit_count <= 4'd0;
                     state     <= ST_DECODE;
                  end else if (bit_count != 4'd0) begin
                     bit_count <= bit_count + 4'd1;
                  end
               end
            end
            ST_DECODE: state <= out_free ? ST_SHIFT : ST_HOLD;
            ST_HOLD:   if (out_free) state <= ST_SHIFT;
            default:   state <= ST_SHIFT;
         endcase
      end
   end

   assign code = frame[11:0];

   assign syndrome[0] = code[0] ^ code[2] ^ code[4] ^ code[6] ^ code[8] ^ code[10];
   assign syndrome[1] = code[1] ^ code[2] ^ code[5] ^ code[6] ^ code[9] ^ code[10];
   assign syndrome[2] = code[3] ^ code[4] ^ code[5] ^ code[6] ^ code[11];
   assign syndrome[3] = code[7] ^ code[8] ^ code[9] ^ code[10] ^ code[11];

`ifdef HAMMING_SECDED_EN
   logic overall;
   // Odd overall parity means exactly one bit flipped; a nonzero syndrome
   // with even parity means two flips, which cannot be located.
   assign overall = ^frame;
   assign flip_en = overall && (syndrome != 4'd0) && (syndrome <= 4'd12);
   assign corr    = overall && (syndrome <= 4'd12);
   assign uncorr  = (syndrome > 4'd12) || (!overall && (syndrome != 4'd0));
`else
   assign flip_en = (syndrome != 4'd0) && (syndrome <= 4'd12);
   assign corr    = flip_en;
   assign uncorr  = (syndrome > 4'd12);
`endif

   // One-hot flip of the bit at position == syndrome (H index syndrome-1).
   generate
      for (genvar gi = 0; gi < 12; gi++) begin : g_flip
         assign flip_mask[gi] = flip_en && (syndrome == 4'(gi + 1));
      end
   endgenerate

   assign fixed = code ^ flip_mask;
   assign data  = {fixed[11:8], fixed[6:4], fixed[2]};

   // Output stage: load a decoded word when empty or being drained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid     <= 1'b0;
         m_data      <= 8'd0;
         m_corrected <= 1'b0;
         m_err_pos   <= 4'd0;
         m_uncorr    <= 1'b0;
      end else if (load_out) begin
         m_valid     <= 1'b1;
         m_data      <= data;
         m_corrected <= corr;
         m_err_pos   <= syndrome;
         m_uncorr    <= uncorr;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule
